// File: rtl/microrv32_periph_pkg.sv
// Shared definitions for MicroRV32 memory-mapped peripherals.
//  - UART register offsets (byte offsets, word aligned)
//  - STATUS register bit positions
//  - FSM state encodings for the UART bus responder and serialiser
//  - clamp_div: lower bound applied to the UART bit divisor
package microrv32_periph_pkg;

    localparam logic [7:0] UART_TXDATA  = 8'h00;
    localparam logic [7:0] UART_STATUS  = 8'h04;
    localparam logic [7:0] UART_BAUDDIV = 8'h08;

    localparam int STAT_FULL      = 0;
    localparam int STAT_EMPTY     = 1;
    localparam int STAT_BUSY      = 2;
    localparam int STAT_COUNT_LSB = 8;

    typedef enum logic {
        BUS_IDLE,
        BUS_ACK
    } bus_state_t;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_t;

    // A divisor below 2 would give zero- or one-cycle bits that the
    // down-counter cannot time, so it is floored at 2.
    function automatic logic [15:0] clamp_div(input logic [15:0] v);
        return (v < 16'd2) ? 16'd2 : v;
    endfunction

endpackage

// File: rtl/microrv32_sync_fifo.sv
// Synchronous FIFO with occupancy count.
//  clk, reset     : clock, asynchronous active-low reset
//  push, wdata    : write request/data; ignored while full
//  pop, rdata     : read request; rdata shows the head entry (valid when !empty)
//  full, empty    : occupancy flags
//  count          : number of stored entries (0..DEPTH)
// DEPTH must be a power of two so the pointers wrap naturally.
module microrv32_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      cnt;
    logic             do_push;
    logic             do_pop;

    assign full    = (cnt == (AW+1)'(DEPTH));
    assign empty   = (cnt == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];
    assign count   = cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    // Storage carries no reset; entries are only read after being written.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/microrv32_uart_tx.sv
// MicroRV32 memory-mapped UART transmitter (8N1).
//  clk, reset       : clock, asynchronous active-low reset
//  bus_valid/write  : request handshake, held until bus_ready
//  bus_addr         : byte offset (0x0 TXDATA, 0x4 STATUS, 0x8 BAUDDIV)
//  bus_wdata/wstrb  : write data and byte strobes
//  bus_ready        : one-cycle acknowledge
//  bus_rdata        : read data, non-zero only during bus_ready
//  tx               : serial output, idle high, registered
//  tx_idle          : FIFO empty and serialiser idle, registered
module microrv32_uart_tx
    import microrv32_periph_pkg::*;
#(
    parameter int FIFO_DEPTH  = 8,
    parameter int DEFAULT_DIV = 868,
    parameter int ADDR_W      = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              bus_valid,
    input  logic              bus_write,
    input  logic [ADDR_W-1:0] bus_addr,
    input  logic [31:0]       bus_wdata,
    input  logic [3:0]        bus_wstrb,
    output logic              bus_ready,
    output logic [31:0]       bus_rdata,
    output logic              tx,
    output logic              tx_idle
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    bus_state_t        bus_state, bus_state_nxt;
    tx_state_t         tx_state, tx_state_nxt;
    logic              cooldown;
    logic [31:0]       rdata_q, rdata_nxt;
    logic [15:0]       baud_div, baud_div_nxt, baud_wr;
    logic [ADDR_W-1:0] addr_word;
    logic              sel_txdata, sel_status, sel_baud;
    logic              push_req, accept;
    logic              fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [7:0]        fifo_rdata;
    logic [CW-1:0]     fifo_count;
    logic [31:0]       status_word;
    logic [7:0]        shreg, shreg_nxt;
    logic [2:0]        bit_idx, bit_idx_nxt;
    logic [15:0]       timer, timer_nxt, div_q, div_nxt;
    logic              tx_nxt, tx_idle_nxt;
    logic              unused_bits;

    assign unused_bits = ^{bus_addr[1:0], bus_wdata[31:16], bus_wstrb[3:2]};

    assign addr_word  = {bus_addr[ADDR_W-1:2], 2'b00};
    assign sel_txdata = (addr_word == ADDR_W'(UART_TXDATA));
    assign sel_status = (addr_word == ADDR_W'(UART_STATUS));
    assign sel_baud   = (addr_word == ADDR_W'(UART_BAUDDIV));

    // A push to a full FIFO is held off (no accept) rather than dropped.
    assign push_req  = bus_write && sel_txdata && bus_wstrb[0];
    assign accept    = (bus_state == BUS_IDLE) && bus_valid && !cooldown &&
                       !(push_req && fifo_full);
    assign fifo_push = accept && push_req;

    always_comb begin
        status_word = '0;
        status_word[STAT_FULL]  = fifo_full;
        status_word[STAT_EMPTY] = fifo_empty;
        status_word[STAT_BUSY]  = (tx_state != TX_IDLE);
        status_word[STAT_COUNT_LSB +: 8] = 8'(fifo_count);
    end

    assign baud_wr = {bus_wstrb[1] ? bus_wdata[15:8] : baud_div[15:8],
                      bus_wstrb[0] ? bus_wdata[7:0]  : baud_div[7:0]};

    microrv32_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (fifo_push),
        .wdata (bus_wdata[7:0]),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Bus responder. rdata_nxt defaults to 0 so bus_rdata is only
    // non-zero while ACK is presented.
    always_comb begin
        bus_state_nxt = bus_state;
        rdata_nxt     = '0;
        baud_div_nxt  = baud_div;
        case (bus_state)
            BUS_IDLE: begin
                if (accept) begin
                    bus_state_nxt = BUS_ACK;
                    if (!bus_write) begin
                        if (sel_status)    rdata_nxt = status_word;
                        else if (sel_baud) rdata_nxt = {16'b0, baud_div};
                    end else if (sel_baud && |bus_wstrb[1:0]) begin
                        baud_div_nxt = clamp_div(baud_wr);
                    end
                end
            end
            BUS_ACK:  bus_state_nxt = BUS_IDLE;
            default:  bus_state_nxt = BUS_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bus_state <= BUS_IDLE;
            rdata_q   <= '0;
            baud_div  <= 16'(DEFAULT_DIV);
            cooldown  <= 1'b0;
        end else begin
            bus_state <= bus_state_nxt;
            rdata_q   <= rdata_nxt;
            baud_div  <= baud_div_nxt;
            // The cycle after ACK ignores bus_valid so the initiator can
            // drop or change its request.
            cooldown  <= (bus_state == BUS_ACK);
        end
    end

    assign bus_ready = (bus_state == BUS_ACK);
    assign bus_rdata = rdata_q;

    // Serialiser. The bit timer counts down from div-1, so each bit lasts
    // exactly div cycles; div_q freezes BAUDDIV for the whole frame.
    always_comb begin
        tx_state_nxt = tx_state;
        shreg_nxt    = shreg;
        bit_idx_nxt  = bit_idx;
        timer_nxt    = (timer != '0) ? timer - 16'd1 : timer;
        div_nxt      = div_q;
        fifo_pop     = 1'b0;
        case (tx_state)
            TX_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop     = 1'b1;
                    shreg_nxt    = fifo_rdata;
                    div_nxt      = baud_div;
                    timer_nxt    = baud_div - 16'd1;
                    tx_state_nxt = TX_START;
                end
            end
            TX_START: begin
                if (timer == '0) begin
                    bit_idx_nxt  = '0;
                    timer_nxt    = div_q - 16'd1;
                    tx_state_nxt = TX_DATA;
                end
            end
            TX_DATA: begin
                if (timer == '0) begin
                    shreg_nxt   = {1'b0, shreg[7:1]};
                    bit_idx_nxt = bit_idx + 3'd1;
                    timer_nxt   = div_q - 16'd1;
                    if (bit_idx == 3'd7) tx_state_nxt = TX_STOP;
                end
            end
            TX_STOP: begin
                if (timer == '0) begin
                    if (!fifo_empty) begin
                        // Back-to-back frame: no idle gap after the stop bit.
                        fifo_pop     = 1'b1;
                        shreg_nxt    = fifo_rdata;
                        div_nxt      = baud_div;
                        timer_nxt    = baud_div - 16'd1;
                        tx_state_nxt = TX_START;
                    end else begin
                        tx_state_nxt = TX_IDLE;
                    end
                end
            end
            default: tx_state_nxt = TX_IDLE;
        endcase

        // tx is computed from the next state so the flop output lines up
        // exactly with the state register.
        case (tx_state_nxt)
            TX_START: tx_nxt = 1'b0;
            TX_DATA:  tx_nxt = shreg_nxt[0];
            default:  tx_nxt = 1'b1;
        endcase

        // If the serialiser stays idle nothing was popped, so the FIFO is
        // empty next cycle unless the bus pushes now.
        tx_idle_nxt = (tx_state_nxt == TX_IDLE) && fifo_empty && !fifo_push;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_state <= TX_IDLE;
            shreg    <= '0;
            bit_idx  <= '0;
            timer    <= '0;
            div_q    <= 16'(DEFAULT_DIV);
            tx       <= 1'b1;
            tx_idle  <= 1'b1;
        end else begin
            tx_state <= tx_state_nxt;
            shreg    <= shreg_nxt;
            bit_idx  <= bit_idx_nxt;
            timer    <= timer_nxt;
            div_q    <= div_nxt;
            tx       <= tx_nxt;
            tx_idle  <= tx_idle_nxt;
        end
    end

endmodule
